pio_rx_drain_arb: RTL and testbench
===================================

# pio_rx_drain_arb

Round-robin arbiter that drains the RX FIFOs of four PIO state machines into one shared output stream for the system bus / DMA side. It selects one eligible FIFO per cycle, pops it, and registers the word with its source index into a single-entry output stage under a valid/ready handshake. It also records per-SM sticky stall flags when an enabled RX FIFO sits full without being serviced.

## Interface
- WIDTH, 32, data width of each FIFO word and of the output stream
- NUM_SM is fixed at 4; all per-SM vectors are 4 bits, index 0..3

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  4  per-SM drain enable
- fifo_empty  input  4  per-SM RX FIFO empty
- fifo_full  input  4  per-SM RX FIFO full
- fifo_level  input  12  per-SM fill level, 3 bits each, SM i at [3i+2:3i], range 0..4
- fifo_dout  input  4*WIDTH  per-SM head word, SM i at [WIDTH*i +: WIDTH], valid same cycle as !fifo_empty
- fifo_pull  output  4  per-SM pop strobe, at most one bit set
- out_valid  output  1  output stage holds a word
- out_data  output  WIDTH  registered word
- out_sm  output  2  source SM of out_data
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- hi_thresh  input  3  watermark level, used only with the watermark feature
- stall_sticky  output  4  per-SM sticky stall flag
- stall_clr  input  4  write-1-to-clear for stall_sticky

## Operation
- Eligible set: E[i] = en[i] && !fifo_empty[i].
- Load condition: load = (!out_valid || out_ready) && |E.
- On load, grant g is the first eligible SM in the order ptr+1, ptr+2, ptr+3, ptr (mod 4). The most recently granted SM therefore has the lowest priority.
- fifo_pull[g] is asserted combinationally in the load cycle. At the clock edge: out_data <= fifo_dout[g], out_sm <= g, out_valid <= 1, ptr <= g.
- If out_valid && out_ready && no eligible SM: out_valid <= 0. out_data and out_sm hold their values.
- If out_valid && !out_ready: the stage holds, and fifo_pull stays 0.
- Deasserting en[i] never affects a word already in the output stage.
- Stall flags:
  - stall_sticky[i] sets in any cycle with en[i] && fifo_full[i] && !fifo_pull[i].
  - stall_clr[i] clears the flag.
  - If set and clear occur in the same cycle, set wins.
- fifo_pull is forced to 0 while reset is high.

## Timing
- Reset values: out_valid 0, out_data 0, out_sm 0, stall_sticky 0, ptr 3. With ptr 3, the first search starts at SM0.
- Latency: a head word popped in cycle N appears on out_data with out_valid high in cycle N+1.
- Throughput: 1 word/clk while out_ready is held high and any SM is eligible.
- Pop and accept in the same cycle are legal. The old word is consumed and the new word is loaded at the same edge.
- Reset asserted mid-operation clears the output stage immediately and discards its word. FIFO contents are not affected. No pull is issued while reset is high.
- Fairness bound: with all four SMs continuously eligible and out_ready high, each SM is granted exactly once in every 4 consecutive loads.

## Configuration
- PIO_RX_ARB_WATERMARK_EN defined:
  - hi[i] = E[i] && (hi_thresh != 0) && (fifo_level[i] >= hi_thresh).
  - If |hi, the grant is the round-robin winner over the hi set only, using the same ptr order. Otherwise it is the round-robin winner over E.
  - ptr always updates to the granted SM.
- PIO_RX_ARB_WATERMARK_EN undefined: pure round-robin over E. hi_thresh is ignored.

## Test plan
- Reset, then all en=1, all FIFOs non-empty, out_ready=1 -> fifo_pull sequence 0001, 0010, 0100, 1000, 0001. out_sm sequence 0,1,2,3 starting one cycle later, with out_data equal to each head word.
- Only SM2 eligible, out_ready=0 -> one pull, out_valid=1 with out_sm=2 held. No further pull until out_ready=1, then back-to-back pulls from SM2.
- SM1 fifo_full=1 and en=1 while out_ready=0 for 3 cycles -> stall_sticky=0010. Pulse stall_clr=0010 while the condition persists -> flag stays 1 (set wins). Remove the condition, then clear -> 0000.
- Assert reset while out_valid=1 with out_data=0xDEADBEEF -> out_valid and out_data read 0 in the same cycle. The first grant after release is SM0.
- Watermark build: hi_thresh=3, SM3 level 4, SM0..2 level 1, ptr=3, out_ready=1 -> SM3 granted first. With the macro off, SM0 is granted first.
- en cleared for SM0 while its word sits in the output stage -> word still delivered with out_sm=0. SM0 gets no further pulls.

Source files
------------

// File: rtl/pio_rx_drain_arb.sv
// Round-robin drain of four PIO RX FIFOs into one registered output stage.
// Optional watermark priority: define PIO_RX_ARB_WATERMARK_EN.
module pio_rx_drain_arb #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         en,
  input  logic [3:0]         fifo_empty,
  input  logic [3:0]         fifo_full,
  input  logic [11:0]        fifo_level,
  input  logic [4*WIDTH-1:0] fifo_dout,
  output logic [3:0]         fifo_pull,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sm,
  input  logic               out_ready,
  input  logic [2:0]         hi_thresh,
  output logic [3:0]         stall_sticky,
  input  logic [3:0]         stall_clr
);

  logic [3:0]       elig;
  logic [3:0]       req;
  logic [1:0]       ptr;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] sel;

  assign elig = en & ~fifo_empty;

`ifdef PIO_RX_ARB_WATERMARK_EN
  logic [3:0] hi;

  always_comb begin
    hi = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hi[i] = elig[i] && (hi_thresh != 3'd0)
              && (fifo_level[3*i +: 3] >= hi_thresh);
    end
  end

  // Urgent FIFOs preempt, but rotation order is shared.
  assign req = (|hi) ? hi : elig;
`else
  logic unused_wm;

  assign unused_wm = ^{fifo_level, hi_thresh};
  assign req       = elig;
`endif

  // Search ptr+1 .. ptr+4; last winner ends up last.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant == 2'(i)) sel = fifo_dout[i*WIDTH +: WIDTH];
    end
  end

  assign load = (!out_valid || out_ready) && (|elig);

  always_comb begin
    fifo_pull = 4'b0000;
    if (load && !reset) fifo_pull = 4'(4'b0001 << grant);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sm    <= 2'd0;
      ptr       <= 2'd3;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel;
      out_sm    <= grant;
      ptr       <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Set dominates clear so a persisting stall is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_sticky <= 4'b0000;
    end else begin
      stall_sticky <= (stall_sticky & ~stall_clr)
                    | (en & fifo_full & ~fifo_pull);
    end
  end

endmodule

// File: tb/tb_pio_rx_drain_arb.sv
// Directed bench for pio_rx_drain_arb.
module tb_pio_rx_drain_arb;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     en;
  logic [3:0]     fifo_empty;
  logic [3:0]     fifo_full;
  logic [11:0]    fifo_level;
  logic [4*W-1:0] fifo_dout;
  logic [3:0]     fifo_pull;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sm;
  logic           out_ready;
  logic [2:0]     hi_thresh;
  logic [3:0]     stall_sticky;
  logic [3:0]     stall_clr;

  logic [W-1:0] din [4];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) fifo_dout[i*W +: W] = din[i];
  end

  pio_rx_drain_arb #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .fifo_dout(fifo_dout),
    .fifo_pull(fifo_pull), .out_valid(out_valid),
    .out_data(out_data), .out_sm(out_sm),
    .out_ready(out_ready), .hi_thresh(hi_thresh),
    .stall_sticky(stall_sticky), .stall_clr(stall_clr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] p1 [5];
  logic [1:0] s1 [5];
  logic [3:0] p6 [4];
  logic [1:0] s6 [4];
  logic [3:0] wm_exp;

  initial begin
    p1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    s1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    p6 = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    s6 = '{2'd1, 2'd2, 2'd3, 2'd1};
    din[0] = 32'hA000_0000;
    din[1] = 32'hA111_1111;
    din[2] = 32'hA222_2222;
    din[3] = 32'hA333_3333;
    reset      = 1'b1;
    en         = 4'hF;
    fifo_empty = 4'h0;
    fifo_full  = 4'h0;
    fifo_level = '0;
    out_ready  = 1'b1;
    hi_thresh  = 3'd0;
    stall_clr  = 4'h0;
    #2;
    chk("rst_pull", 32'(fifo_pull), 32'h0);
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_sm", 32'(out_sm), 32'h0);
    chk("rst_stall", 32'(stall_sticky), 32'h0);
    reset = 1'b0;

    // round-robin from SM0, one word per clock
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_pull", 32'(fifo_pull), 32'(p1[k]));
      tick();
      chk("rr_sm", 32'(out_sm), 32'(s1[k]));
      chk("rr_data", out_data, din[s1[k]]);
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // drain with nothing eligible
    en = 4'h0;
    #1;
    chk("drain_pull", 32'(fifo_pull), 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_hold_sm", 32'(out_sm), 32'h0);
    chk("drain_hold_data", out_data, din[0]);

    // only SM2, backpressure
    en = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("bp_pull0", 32'(fifo_pull), 32'h4);
    tick();
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_sm", 32'(out_sm), 32'h2);
    #1;
    chk("bp_nopull", 32'(fifo_pull), 32'h0);
    tick();
    chk("bp_hold_sm", 32'(out_sm), 32'h2);
    chk("bp_hold_pull", 32'(fifo_pull), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_pull1", 32'(fifo_pull), 32'h4);
    tick();
    chk("bp_sm1", 32'(out_sm), 32'h2);
    chk("bp_pull2", 32'(fifo_pull), 32'h4);

    // sticky stall on SM1
    en = 4'b0010;
    fifo_full = 4'b0010;
    out_ready = 1'b0;
    #1;
    chk("st_nopull", 32'(fifo_pull), 32'h0);
    tick();
    tick();
    tick();
    chk("st_set", 32'(stall_sticky), 32'h2);
    stall_clr = 4'b0010;
    tick();
    chk("st_setwins", 32'(stall_sticky), 32'h2);
    fifo_full = 4'h0;
    stall_clr = 4'h0;
    tick();
    chk("st_keep", 32'(stall_sticky), 32'h2);
    stall_clr = 4'b0010;
    tick();
    chk("st_clr", 32'(stall_sticky), 32'h0);
    stall_clr = 4'h0;

    // reset mid-operation discards the stage
    din[1] = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #1;
    chk("mr_pull", 32'(fifo_pull), 32'h2);
    tick();
    chk("mr_data", out_data, 32'hDEAD_BEEF);
    chk("mr_sm", 32'(out_sm), 32'h1);
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mr_valid0", 32'(out_valid), 32'h0);
    chk("mr_data0", out_data, 32'h0);
    chk("mr_pull0", 32'(fifo_pull), 32'h0);
    tick();
    reset = 1'b0;
    en = 4'hF;
    out_ready = 1'b1;
    fifo_level = {3'd4, 3'd1, 3'd1, 3'd1};
    hi_thresh = 3'd3;
`ifdef PIO_RX_ARB_WATERMARK_EN
    wm_exp = 4'b1000;
`else
    wm_exp = 4'b0001;
`endif
    #1;
    chk("wm_pull", 32'(fifo_pull), 32'(wm_exp));
    hi_thresh = 3'd0;
    #1;
    chk("post_rst_pull", 32'(fifo_pull), 32'h1);
    tick();
    chk("post_rst_sm", 32'(out_sm), 32'h0);
    chk("post_rst_valid", 32'(out_valid), 32'h1);

    // disabling SM0 keeps its staged word
    out_ready = 1'b0;
    en = 4'b1110;
    #1;
    chk("en_nopull", 32'(fifo_pull), 32'h0);
    tick();
    chk("en_valid", 32'(out_valid), 32'h1);
    chk("en_sm", 32'(out_sm), 32'h0);
    chk("en_data", out_data, din[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("en_pull", 32'(fifo_pull), 32'(p6[k]));
      tick();
      chk("en_rr_sm", 32'(out_sm), 32'(s6[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
